frame_sequencer: RTL and testbench

//  Instruction-fetch sequencer feeding 17-bit frames into the CPU core's frame input.

---
 rtl/frame_sequencer.sv | 122 ++++++++++++
 tb/tb_frame_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: instruction-fetch sequencer for the CPU core.
// Owns the program counter. Reads 17-bit frames from a synchronous instruction
// memory that has a 1-cycle read latency, and hands each frame to the core with
// a valid/ready handshake. Follows branch redirects from the core and stops
// fetching when it reads the HALT opcode.
// Ports:
//   sysclk, reset         clock (rising edge), synchronous active-high reset
//   run                   fetch enable; low parks the sequencer in IDLE
//   imem_rd, imem_addr    read strobe and address to instruction memory
//   imem_rdata            read data, valid the cycle after imem_rd
//   frame, frame_valid    frame to the core and its valid flag
//   frame_ready           core accepts the frame this cycle
//   redirect, redirect_pc branch taken by the core and its target
//   pc                    address of the next frame to fetch
//   halted                HALT opcode fetched; sequencer stopped
module frame_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     FRAME_W  = 17,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [FRAME_W-1:0] imem_rdata,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t state;

  logic [OP_W-1:0] rd_opcode;
  assign rd_opcode = imem_rdata[FRAME_W-1 -: OP_W];

  // The read address is always the current pc.
  assign imem_addr = pc;

  // Sequencer FSM. imem_rd is registered, so it is set on entry to FETCH and
  // defaults to 0 every cycle; it is therefore high only while in FETCH.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      frame       <= '0;
      frame_valid <= 1'b0;
      imem_rd     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      imem_rd <= 1'b0;
      if (redirect && (state != S_IDLE)) begin
        // Redirect beats the normal transition. Read data still in flight is
        // ignored, and a held frame is dropped. A simultaneous handshake counts
        // as consumed.
        pc          <= redirect_pc;
        halted      <= 1'b0;
        frame_valid <= 1'b0;
        imem_rd     <= 1'b1;
        state       <= S_FETCH;
      end else begin
        case (state)
          S_IDLE: begin
            if (redirect) begin
              pc <= redirect_pc;
            end else if (run) begin
              imem_rd <= 1'b1;
              state   <= S_FETCH;
            end
          end
          S_FETCH: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (rd_opcode == HALT_OP) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              frame       <= imem_rdata;
              frame_valid <= 1'b1;
              pc          <= pc + PC_W'(1);
              state       <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (frame_ready) begin
              frame_valid <= 1'b0;
              if (run) begin
                imem_rd <= 1'b1;
                state   <= S_FETCH;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_HALT: begin
            state <= S_HALT;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer. A behavioural synchronous memory
// supplies the frames. Inputs change 1 time unit after the rising edge, and
// outputs are checked at that same point.
module tb_frame_sequencer;

  logic        sysclk;
  logic        reset;
  logic        run;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [16:0] imem_rdata;
  logic [16:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic        halted;

  logic [16:0] mem [0:255];

  int checks;
  int failures;

  frame_sequencer dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .run         (run),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .halted      (halted)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Synchronous instruction memory with a 1-cycle read latency.
  always @(posedge sysclk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    run         = 1'b0;
    frame_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_imem_rd got=%b exp=0", imem_rd); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (frame !== 17'h0) begin failures++; $display("FAIL reset_frame got=%h exp=00000", frame); end
    // With run low the sequencer stays in IDLE.
    tick();
    tick();
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL idle_no_fetch got=%b exp=0", imem_rd); end
  endtask

  // Two frames with ready held high, then a HALT at address 2.
  task automatic test_basic_fetch();
    logic [5:0] exp_rd;
    logic [5:0] exp_fv;
    exp_rd = 6'b001001;  // cycles 1 and 4
    exp_fv = 6'b100100;  // cycles 3 and 6
    mem[0] = 17'h02220;
    mem[1] = 17'h06000;
    mem[2] = 17'h1E000;
    do_reset();
    run = 1'b1;
    frame_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++; if (imem_rd !== exp_rd[c-1]) begin failures++; $display("FAIL t1_imem_rd cycle=%0d got=%b exp=%b", c, imem_rd, exp_rd[c-1]); end
      checks++; if (frame_valid !== exp_fv[c-1]) begin failures++; $display("FAIL t1_frame_valid cycle=%0d got=%b exp=%b", c, frame_valid, exp_fv[c-1]); end
      if (c == 1) begin
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL t1_addr0 got=%h exp=00", imem_addr); end
      end
      if (c == 4) begin
        checks++; if (imem_addr !== 8'h01) begin failures++; $display("FAIL t1_addr1 got=%h exp=01", imem_addr); end
      end
      if (c == 3) begin
        checks++; if (frame !== 17'h02220) begin failures++; $display("FAIL t1_frame0 got=%h exp=02220", frame); end
      end
      if (c == 6) begin
        checks++; if (frame !== 17'h06000) begin failures++; $display("FAIL t1_frame1 got=%h exp=06000", frame); end
        checks++; if (pc !== 8'h02) begin failures++; $display("FAIL t1_pc got=%h exp=02", pc); end
      end
    end
    // cycle 7 FETCH addr 2, cycle 8 WAIT, cycle 9 HALT
    tick();
    checks++; if (imem_addr !== 8'h02 || imem_rd !== 1'b1) begin failures++; $display("FAIL t1_addr2 got=%h/%b exp=02/1", imem_addr, imem_rd); end
    tick();
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL t1_halted got=%b exp=1", halted); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t1_halt_fv got=%b exp=0", frame_valid); end
    checks++; if (pc !== 8'h02) begin failures++; $display("FAIL t1_halt_pc got=%h exp=02", pc); end
  endtask

  // Core stalls for 5 cycles; run drops while the frame is held.
  task automatic test_stall();
    mem[0] = 17'h02220;
    do_reset();
    run = 1'b1;
    frame_ready = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL t2_valid i=%0d got=%b exp=1", i, frame_valid); end
      checks++; if (frame !== 17'h02220) begin failures++; $display("FAIL t2_frame i=%0d got=%h exp=02220", i, frame); end
      checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL t2_no_rd i=%0d got=%b exp=0", i, imem_rd); end
      checks++; if (pc !== 8'h01) begin failures++; $display("FAIL t2_pc i=%0d got=%h exp=01", i, pc); end
      if (i == 3) run = 1'b0;
      tick();
    end
    frame_ready = 1'b1;
    tick();
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t2_consumed got=%b exp=0", frame_valid); end
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL t2_park_rd got=%b exp=0", imem_rd); end
    tick();
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL t2_idle_rd got=%b exp=0", imem_rd); end
  endtask

  // Redirect while a read is in flight.
  task automatic test_redirect_wait();
    mem[0]    = 17'h02220;
    mem[8'h40] = 17'h04444;
    do_reset();
    run = 1'b1;
    frame_ready = 1'b0;
    tick();  // FETCH
    tick();  // WAIT
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    checks++; if (imem_rd !== 1'b1) begin failures++; $display("FAIL t3_rd got=%b exp=1", imem_rd); end
    checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL t3_addr got=%h exp=40", imem_addr); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t3_fv got=%b exp=0", frame_valid); end
    tick();
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t3_fv_wait got=%b exp=0", frame_valid); end
    tick();
    checks++; if (frame_valid !== 1'b1 || frame !== 17'h04444) begin failures++; $display("FAIL t3_new_frame got=%b/%h exp=1/04444", frame_valid, frame); end
    checks++; if (pc !== 8'h41) begin failures++; $display("FAIL t3_pc got=%h exp=41", pc); end
  endtask

  // HALT at address 5, then a redirect back to 0.
  task automatic test_halt();
    mem[0] = 17'h02220;
    mem[5] = 17'h1E000;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 8'h05;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 8'h05 || imem_rd !== 1'b0) begin failures++; $display("FAIL t4_idle_redirect got=%h/%b exp=05/0", pc, imem_rd); end
    run = 1'b1;
    frame_ready = 1'b1;
    tick();  // FETCH
    checks++; if (imem_addr !== 8'h05) begin failures++; $display("FAIL t4_addr got=%h exp=05", imem_addr); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t4_fv i=%0d got=%b exp=0", i, frame_valid); end
      checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL t4_rd i=%0d got=%b exp=0", i, imem_rd); end
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL t4_halted got=%b exp=1", halted); end
    checks++; if (pc !== 8'h05) begin failures++; $display("FAIL t4_pc got=%h exp=05", pc); end
    redirect = 1'b1;
    redirect_pc = 8'h00;
    tick();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL t4_unhalt got=%b exp=0", halted); end
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL t4_refetch got=%b/%h exp=1/00", imem_rd, imem_addr); end
    tick();
    tick();
    checks++; if (frame_valid !== 1'b1 || frame !== 17'h02220) begin failures++; $display("FAIL t4_issue got=%b/%h exp=1/02220", frame_valid, frame); end
  endtask

  // pc wraps from FF to 00.
  task automatic test_wrap();
    mem[8'hFF] = 17'h0ABCD;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    run = 1'b1;
    frame_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (frame_valid !== 1'b1 || frame !== 17'h0ABCD) begin failures++; $display("FAIL t5_frame got=%b/%h exp=1/0abcd", frame_valid, frame); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL t5_pc got=%h exp=00", pc); end
    tick();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL t5_next got=%b/%h exp=1/00", imem_rd, imem_addr); end
  endtask

  // Handshake and redirect in the same cycle.
  task automatic test_back_to_back();
    mem[0]     = 17'h02220;
    mem[8'h20] = 17'h04444;
    do_reset();
    run = 1'b1;
    frame_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", frame_valid); end
    redirect = 1'b1;
    redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL b2b_fv got=%b exp=0", frame_valid); end
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h20) begin failures++; $display("FAIL b2b_fetch got=%b/%h exp=1/20", imem_rd, imem_addr); end
    tick(); tick();
    checks++; if (frame_valid !== 1'b1 || frame !== 17'h04444) begin failures++; $display("FAIL b2b_frame got=%b/%h exp=1/04444", frame_valid, frame); end
  endtask

  // Reset arrives while a frame is held; reset beats redirect and ready.
  task automatic test_reset_in_issue();
    mem[0] = 17'h02220;
    do_reset();
    run = 1'b1;
    frame_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (frame_valid !== 1'b1 || pc !== 8'h01) begin failures++; $display("FAIL t6_pre got=%b/%h exp=1/01", frame_valid, pc); end
    reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'h33;
    frame_ready = 1'b1;
    tick();
    reset = 1'b0;
    redirect = 1'b0;
    run = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t6_fv got=%b exp=0", frame_valid); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL t6_pc got=%h exp=00", pc); end
    checks++; if (frame !== 17'h0 || imem_rd !== 1'b0) begin failures++; $display("FAIL t6_frame got=%h/%b exp=00000/0", frame, imem_rd); end
    tick();
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL t6_idle got=%b exp=0", imem_rd); end
    run = 1'b1;
    tick();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL t6_restart got=%b/%h exp=1/00", imem_rd, imem_addr); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    run         = 1'b0;
    frame_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    imem_rdata  = 17'h0;
    for (int a = 0; a < 256; a++) mem[a] = 17'h00000;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_reset_in_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
